// File: rtl/iob_ila_pgen_if.sv
// rtl/iob_ila_pgen_if.sv - buffer write, run control, trigger and playback signals of iob_ila_pgen
// Signals:
//   wr_en_i/wr_addr_i/wr_sel_i/wr_data_i - sample buffer word write port
//   start_i/stop_i                        - run control pulses
//   last_i/prescale_i/loop_i              - run configuration, latched on start
//   trig_en_i/trig_edge_i/trig_neg_i      - trigger configuration, latched on start
//   trigger_i                             - external trigger
//   signal_o/sample_stb_o/pos_o           - played sample, new-sample strobe, sample index
//   busy_o/armed_o/done_o                 - status
// Modports: master drives the inputs of the generator, slave is the generator itself.
interface iob_ila_pgen_if #(
  parameter int DATA_W     = 32,
  parameter int SIGNAL_W   = 32,
  parameter int BUFFER_W   = 10,
  parameter int PRESCALE_W = 16
);
  localparam int SEL_W = (DATA_W >= SIGNAL_W) ? 1 :
                         $clog2((SIGNAL_W + DATA_W - 1) / DATA_W);

  logic                  wr_en_i;
  logic [BUFFER_W-1:0]   wr_addr_i;
  logic [SEL_W-1:0]      wr_sel_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  start_i;
  logic                  stop_i;
  logic [BUFFER_W-1:0]   last_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic                  loop_i;
  logic                  trig_en_i;
  logic                  trig_edge_i;
  logic                  trig_neg_i;
  logic                  trigger_i;
  logic [SIGNAL_W-1:0]   signal_o;
  logic                  sample_stb_o;
  logic [BUFFER_W-1:0]   pos_o;
  logic                  busy_o;
  logic                  armed_o;
  logic                  done_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_sel_i, wr_data_i,
    output start_i, stop_i, last_i, prescale_i, loop_i,
    output trig_en_i, trig_edge_i, trig_neg_i, trigger_i,
    input  signal_o, sample_stb_o, pos_o, busy_o, armed_o, done_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_sel_i, wr_data_i,
    input  start_i, stop_i, last_i, prescale_i, loop_i,
    input  trig_en_i, trig_edge_i, trig_neg_i, trigger_i,
    output signal_o, sample_stb_o, pos_o, busy_o, armed_o, done_o
  );
endinterface

// File: rtl/iob_ila_pgen.sv
// rtl/iob_ila_pgen.sv - ILA pattern generator: plays a loaded sample buffer onto signal_o
// Ports:
//   clk_i  - system clock
//   arst_i - asynchronous active-high reset
//   bus    - iob_ila_pgen_if.slave: buffer write port, run control, trigger, playback outputs
module iob_ila_pgen #(
  parameter int DATA_W     = 32,
  parameter int SIGNAL_W   = 32,
  parameter int BUFFER_W   = 10,
  parameter int PRESCALE_W = 16
) (
  input  logic          clk_i,
  input  logic          arst_i,
  iob_ila_pgen_if.slave bus
);
  localparam int DEPTH = 1 << BUFFER_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SIGNAL_W-1:0]   r_mem [DEPTH];
  logic [BUFFER_W-1:0]   r_idx;
  logic [BUFFER_W-1:0]   r_last;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_loop;
  logic                  r_trig_edge;
  logic                  r_trig_neg;
  logic                  r_trig_prev;
  logic                  r_fin;
  logic [SIGNAL_W-1:0]   r_sig;
  logic [BUFFER_W-1:0]   r_pos;
  logic                  r_stb;

  logic [31:0]           w_shift;
  logic [SIGNAL_W-1:0]   w_wmask;
  logic [SIGNAL_W-1:0]   w_wdata;
  logic                  w_start_ok;
  logic                  w_fire;
  logic                  w_play;
  logic                  w_hold_end;
  logic                  w_at_last;
  logic                  w_issue;
  logic                  w_busy;
  logic                  w_armed;
  logic                  w_done;

  // Slice write: the mask is clipped to SIGNAL_W by the shift itself.
  assign w_shift = 32'(bus.wr_sel_i) * 32'(DATA_W);
  assign w_wmask = SIGNAL_W'({DATA_W{1'b1}}) << w_shift;
  assign w_wdata = SIGNAL_W'(bus.wr_data_i) << w_shift;

  always_ff @(posedge clk_i) begin
    if (bus.wr_en_i) begin
      r_mem[bus.wr_addr_i] <= (r_mem[bus.wr_addr_i] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  assign w_start_ok = bus.start_i && !bus.stop_i &&
                      (r_state == S_IDLE || r_state == S_DONE);
  // Previous trigger is kept raw so the polarity latched at start applies to both samples.
  assign w_fire     = (r_state == S_ARMED) && (bus.trigger_i ^ r_trig_neg) &&
                      (!r_trig_edge || !(r_trig_prev ^ r_trig_neg));
  // r_fin marks the extra PLAY cycle in which the final sample is still on signal_o.
  assign w_play     = (r_state == S_PLAY) && !r_fin;
  assign w_hold_end = w_play && (r_cnt == r_pre);
  assign w_at_last  = (r_idx == r_last);
  // The buffer read lands directly in signal_o, so the sample shows one cycle after issue.
  assign w_issue    = w_play && !bus.stop_i && (r_cnt == '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_armed     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_start_ok) w_state_nxt = bus.trig_en_i ? S_ARMED : S_PLAY;
      end
      S_ARMED: begin
        w_busy  = 1'b1;
        w_armed = 1'b1;
        if (w_fire) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        w_busy = 1'b1;
        if (r_fin) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.stop_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_idx       <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_pre       <= '0;
      r_loop      <= 1'b0;
      r_trig_edge <= 1'b0;
      r_trig_neg  <= 1'b0;
      r_trig_prev <= 1'b0;
      r_fin       <= 1'b0;
      r_sig       <= '0;
      r_pos       <= '0;
      r_stb       <= 1'b0;
    end else begin
      r_trig_prev <= bus.trigger_i;
      r_fin       <= w_hold_end && w_at_last && !r_loop && !bus.stop_i;
      r_stb       <= w_issue;
      if (w_issue) begin
        r_sig <= r_mem[r_idx];
        r_pos <= r_idx;
      end
      if (w_start_ok) begin
        r_last      <= bus.last_i;
        r_pre       <= bus.prescale_i;
        r_loop      <= bus.loop_i;
        r_trig_edge <= bus.trig_edge_i;
        r_trig_neg  <= bus.trig_neg_i;
      end
      if (bus.stop_i || w_start_ok) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else if (w_hold_end) begin
        r_cnt <= '0;
        // A non-looping run parks on the last index while r_fin drains.
        if (!w_at_last) r_idx <= r_idx + 1'b1;
        else if (r_loop) r_idx <= '0;
      end else if (w_play) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.signal_o     = r_sig;
  assign bus.pos_o        = r_pos;
  assign bus.sample_stb_o = r_stb;
  assign bus.busy_o       = w_busy;
  assign bus.armed_o      = w_armed;
  assign bus.done_o       = w_done;
endmodule

// File: tb/tb_iob_ila_pgen.sv
// tb/tb_iob_ila_pgen.sv - randomized self-checking bench for iob_ila_pgen against a timeline model
module tb_iob_ila_pgen;
  localparam int DW   = 32;
  localparam int SW   = 40;
  localparam int BW   = 3;
  localparam int PW   = 16;
  localparam int SELW = 1;
  localparam int NE   = 1 << BW;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iob_ila_pgen_if #(.DATA_W(DW), .SIGNAL_W(SW), .BUFFER_W(BW), .PRESCALE_W(PW)) bus ();

  iob_ila_pgen #(.DATA_W(DW), .SIGNAL_W(SW), .BUFFER_W(BW), .PRESCALE_W(PW)) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [SW-1:0] mdl_mem [NE];
  logic [SW-1:0] exp_sig = '0;
  int            exp_pos = 0;
  bit            prev_done = 1'b0;
  bit            trig_seq [MAXC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int c, input bit busy, input bit armed, input bit done, input bit stb);
    check($sformatf("signal_o@%0d", c), 64'(bus.signal_o), 64'(exp_sig));
    check($sformatf("pos_o@%0d", c), 64'(bus.pos_o), 64'(exp_pos));
    check($sformatf("sample_stb_o@%0d", c), 64'(bus.sample_stb_o), 64'(stb));
    check($sformatf("busy_o@%0d", c), 64'(bus.busy_o), 64'(busy));
    check($sformatf("armed_o@%0d", c), 64'(bus.armed_o), 64'(armed));
    check($sformatf("done_o@%0d", c), 64'(bus.done_o), 64'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_sel_i = '0; bus.wr_data_i = '0;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.last_i = '0; bus.prescale_i = '0;
    bus.loop_i = 1'b0; bus.trig_en_i = 1'b0; bus.trig_edge_i = 1'b0;
    bus.trig_neg_i = 1'b0; bus.trigger_i = 1'b0;
  endtask

  // Slice sel covers bits sel*DW upward; anything beyond SW is dropped.
  task automatic mdl_write(input int a, input int sel, input logic [DW-1:0] d);
    for (int b = 0; b < DW; b++)
      if (sel * DW + b < SW) mdl_mem[a][sel * DW + b] = d[b];
  endtask

  task automatic wr_now(input int a, input int sel, input logic [DW-1:0] d);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = BW'(a); bus.wr_sel_i = SELW'(sel); bus.wr_data_i = d;
    tick();
    bus.wr_en_i = 1'b0;
    mdl_write(a, sel, d);
  endtask

  // One run: start in cycle 0, observe cycles 0..ncyc. Samples begin two cycles after the
  // start (or after the trigger fire) and advance every pre+1 cycles.
  task automatic run(input int last, input int pre, input bit lp, input bit ten, input bit tedge,
                     input bit tneg, input int ncyc, input int stop_at, input int rst_at,
                     input bit wr_rand);
    int fire, base, d, k, idx, pa, ps;
    bit pend, e_busy, e_armed, e_done, e_stb, t, tp;
    logic [DW-1:0] pd;
    fire = 1 << 30;
    if (ten) begin
      for (int c = 1; c < ncyc; c++) begin
        t  = trig_seq[c] ^ tneg;
        tp = trig_seq[c-1] ^ tneg;
        if (t && (!tedge || !tp)) begin
          fire = c;
          break;
        end
      end
    end
    base = ten ? fire : 0;
    pend = 1'b0; pa = 0; ps = 0; pd = '0;
    e_busy = 1'b0; e_done = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      e_busy = 1'b0; e_armed = 1'b0; e_done = 1'b0; e_stb = 1'b0;
      if (c == 0) begin
        e_done = prev_done;
      end else if (stop_at > 0 && c > stop_at) begin
        e_busy = 1'b0;
      end else if (ten && c <= fire) begin
        e_busy = 1'b1; e_armed = 1'b1;
      end else if (c == base + 1) begin
        e_busy = 1'b1;
      end else begin
        d = c - base - 2;
        k = d / (pre + 1);
        if (lp || k <= last) begin
          idx    = k % (last + 1);
          e_busy = 1'b1;
          e_stb  = (d % (pre + 1)) == 0;
          if (e_stb) begin
            exp_sig = mdl_mem[idx];
            exp_pos = idx;
          end
        end else begin
          e_done = 1'b1;
        end
      end
      check_outs(c, e_busy, e_armed, e_done, e_stb);
      if (pend) mdl_write(pa, ps, pd);
      pend = 1'b0;
      if (c == rst_at) begin
        set_idle();
        #2 rst = 1'b1;
        #1;
        exp_sig = '0; exp_pos = 0; prev_done = 1'b0;
        check_outs(-1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (c == ncyc) break;
      bus.start_i = (c == 0) || (e_busy && $urandom_range(0, 7) == 0);
      bus.stop_i  = (stop_at > 0 && c == stop_at);
      if (c == 0) begin
        bus.last_i = BW'(last); bus.prescale_i = PW'(pre); bus.loop_i = lp;
        bus.trig_en_i = ten; bus.trig_edge_i = tedge; bus.trig_neg_i = tneg;
      end else begin
        bus.last_i = BW'($urandom); bus.prescale_i = PW'($urandom_range(0, 3));
        bus.loop_i = 1'($urandom_range(0, 1)); bus.trig_en_i = 1'($urandom_range(0, 1));
        bus.trig_edge_i = 1'($urandom_range(0, 1)); bus.trig_neg_i = 1'($urandom_range(0, 1));
      end
      bus.trigger_i = trig_seq[c];
      if (wr_rand && $urandom_range(0, 2) == 0) begin
        pend = 1'b1; pa = $urandom_range(0, NE - 1); ps = $urandom_range(0, 1); pd = $urandom;
        bus.wr_en_i = 1'b1; bus.wr_addr_i = BW'(pa); bus.wr_sel_i = SELW'(ps); bus.wr_data_i = pd;
      end else begin
        bus.wr_en_i = 1'b0;
      end
      tick();
    end
    set_idle();
    if (e_busy) begin
      bus.stop_i = 1'b1;
      tick();
      bus.stop_i = 1'b0;
      prev_done = 1'b0;
    end else begin
      prev_done = e_done;
    end
  endtask

  task automatic clear_trig();
    for (int i = 0; i < MAXC; i++) trig_seq[i] = 1'b0;
  endtask

  initial begin
    int last, pre, ncyc, stop_at;
    bit lp, ten, tedge, tneg, wr_r, cur;
    set_idle();
    clear_trig();
    repeat (3) tick();
    check_outs(-1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < NE; a++) begin
      wr_now(a, 0, $urandom);
      wr_now(a, 1, $urandom);
    end
    for (int a = 0; a < 4; a++) begin
      wr_now(a, 0, DW'(32'hA0 + a));
      wr_now(a, 1, '0);
    end

    // Single immediate run A0..A3, then single-sample run from DONE.
    run(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, -1, 1'b0);
    run(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, -1, 1'b0);

    // Upper slice of wide samples with a 3-cycle hold.
    wr_now(0, 1, 32'h12);
    wr_now(1, 1, 32'h12);
    run(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0, -1, 1'b0);

    // Negated edge trigger: 0 held, rises (no fire), falls in cycle 7 (fires).
    clear_trig();
    for (int i = 4; i < 7; i++) trig_seq[i] = 1'b1;
    run(2, 1, 1'b0, 1'b1, 1'b1, 1'b1, 20, 0, -1, 1'b0);

    // Full-buffer loop with natural wrap, then stop.
    clear_trig();
    run(NE - 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 20, 13, -1, 1'b0);

    // start and stop together in IDLE stay in IDLE.
    bus.start_i = 1'b1; bus.stop_i = 1'b1;
    tick();
    set_idle();
    check_outs(-2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs(-3, 1'b0, 1'b0, 1'b0, 1'b0);
    prev_done = 1'b0;

    // Writes during looped play, including to the address being read.
    run(3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 30, 25, -1, 1'b1);

    // Asynchronous reset mid-play, then replay of preserved buffer.
    run(5, 1, 1'b1, 1'b0, 1'b0, 1'b0, 20, 0, 9, 1'b0);
    run(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0, -1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      last  = $urandom_range(0, NE - 1);
      pre   = $urandom_range(0, 3);
      lp    = 1'($urandom_range(0, 1));
      ten   = 1'($urandom_range(0, 1));
      tedge = 1'($urandom_range(0, 1));
      tneg  = 1'($urandom_range(0, 1));
      wr_r  = 1'($urandom_range(0, 1));
      ncyc  = $urandom_range(10, 50);
      stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ncyc - 1) : 0;
      cur = 1'($urandom_range(0, 1));
      for (int i = 0; i < MAXC; i++) begin
        if ($urandom_range(0, 3) == 0) cur = ~cur;
        trig_seq[i] = cur;
      end
      run(last, pre, lp, ten, tedge, tneg, ncyc, stop_at, -1, wr_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
